pipeline_hazard_controller: RTL and testbench



---
 rtl/lc3b_types.sv | 11 +
 rtl/sat_counter.sv | 11 +
 rtl/pipeline_hazard_controller.sv | 60 ++++++
 tb/tb_pipeline_hazard_controller.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b opcode and hazard-controller types
package lc3b_types;
  typedef enum logic [3:0] {
    op_br, op_add, op_ldb, op_stb, op_jsr, op_and, op_ldr, op_str,
    op_rti, op_not, op_ldi, op_sti, op_jmp, op_shf, op_lea, op_trap
  } lc3b_opcode;
  typedef enum logic {RUN, INDIRECT} lc3b_hazard_state;
  function automatic logic is_load(lc3b_opcode op);
    return op inside {op_ldb, op_ldi, op_ldr};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/bubble/flush sequencing for the 5-stage LC-3b pipeline
module pipeline_hazard_controller
  import lc3b_types::*;
#(parameter int CNT_WIDTH = 16) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_id_uses_sr1,
  input  logic                 if_id_uses_sr2,
  input  logic [2:0]           if_id_sr1,
  input  logic [2:0]           if_id_sr2,
  input  logic [3:0]           id_ex_opcode,
  input  logic [2:0]           id_ex_dest,
  input  logic [3:0]           ex_mem_opcode,
  input  logic                 ex_mem_branch_taken,
  input  logic                 icache_resp,
  input  logic                 dcache_req,
  input  logic                 dcache_resp,
  output logic                 pc_load,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 bubble_id_ex,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic                 indirect_phase,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] bubble_count,
  output logic [CNT_WIDTH-1:0] flush_count
);
  lc3b_hazard_state state, state_n;
  logic freeze, ind_first, flush, load_use, go;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_n;
  always_comb begin
    freeze    = !icache_resp | (dcache_req & !dcache_resp) | (state == INDIRECT & !dcache_resp);
    ind_first = !freeze & state == RUN & dcache_resp & (ex_mem_opcode inside {op_ldi, op_sti});
    flush     = !freeze & !ind_first & ex_mem_branch_taken;
    load_use  = !freeze & !ind_first & !flush & is_load(lc3b_opcode'(id_ex_opcode)) &
                ((if_id_uses_sr1 & if_id_sr1 == id_ex_dest) | (if_id_uses_sr2 & if_id_sr2 == id_ex_dest));
    go        = !rst & !freeze & !ind_first;
    // the indirect sequence only finishes on a cycle that actually advances
    state_n        = (ind_first | (state == INDIRECT & freeze)) ? INDIRECT : RUN;
    pc_load        = go & !load_use;
    load_if_id     = go & !load_use;
    load_id_ex     = go;
    load_ex_mem    = go;
    load_mem_wb    = go;
    bubble_id_ex   = !rst & load_use;
    flush_if_id    = !rst & flush;
    flush_id_ex    = !rst & flush;
    flush_ex_mem   = !rst & flush;
    indirect_phase = !rst & state == INDIRECT;
  end
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (.clk, .rst, .inc(freeze | ind_first), .count(stall_count));
  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble (.clk, .rst, .inc(load_use), .count(bubble_count));
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush (.clk, .rst, .inc(flush), .count(flush_count));
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors checked through an expectation queue
module tb_pipeline_hazard_controller;
  localparam int W = 8;
  localparam logic [3:0] BR = 4'd0, ADD = 4'd1, LDB = 4'd2, LDR = 4'd6, LDI = 4'd10;
  localparam logic [4:0] N = 5'b11111, Z = 5'b00000, B = 5'b00111;
  localparam logic [W-1:0] MAXC = '1;
  typedef struct packed {
    logic [9:0]   o;
    logic [W-1:0] s, b, f;
  } exp_t;
  logic clk = 0, rst = 1;
  logic if_id_uses_sr1 = 0, if_id_uses_sr2 = 0, ex_mem_branch_taken = 0;
  logic icache_resp = 1, dcache_req = 0, dcache_resp = 0;
  logic [2:0] if_id_sr1 = 0, if_id_sr2 = 0, id_ex_dest = 0;
  logic [3:0] id_ex_opcode = ADD, ex_mem_opcode = ADD;
  logic pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble_id_ex;
  logic flush_if_id, flush_id_ex, flush_ex_mem, indirect_phase;
  logic [W-1:0] stall_count, bubble_count, flush_count;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  int es = 0, eb = 0, ef = 0;

  pipeline_hazard_controller #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .if_id_uses_sr1(if_id_uses_sr1), .if_id_uses_sr2(if_id_uses_sr2),
    .if_id_sr1(if_id_sr1), .if_id_sr2(if_id_sr2),
    .id_ex_opcode(id_ex_opcode), .id_ex_dest(id_ex_dest),
    .ex_mem_opcode(ex_mem_opcode), .ex_mem_branch_taken(ex_mem_branch_taken),
    .icache_resp(icache_resp), .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .pc_load(pc_load), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .indirect_phase(indirect_phase),
    .stall_count(stall_count), .bubble_count(bubble_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic int sat(int v);
    return v >= int'(MAXC) ? int'(MAXC) : v;
  endfunction

  // o = {pc,if_id,id_ex,ex_mem,mem_wb loads, bubble, 3 flushes, indirect}; ev = {stall,bubble,flush}
  task automatic cyc(input logic r, input logic [3:0] exop, idop, input logic [2:0] dest, s1, s2,
                     input logic u1, u2, bt, ic, dq, dr, input logic [9:0] o, input logic [2:0] ev);
    @(posedge clk);
    #1;
    rst = r; ex_mem_opcode = exop; id_ex_opcode = idop; id_ex_dest = dest;
    if_id_sr1 = s1; if_id_sr2 = s2; if_id_uses_sr1 = u1; if_id_uses_sr2 = u2;
    ex_mem_branch_taken = bt; icache_resp = ic; dcache_req = dq; dcache_resp = dr;
    if (r) begin es = 0; eb = 0; ef = 0; end
    q.push_back('{o: o, s: W'(es), b: W'(eb), f: W'(ef)});
    if (!r) begin
      es = sat(es + int'(ev[2])); eb = sat(eb + int'(ev[1])); ef = sat(ef + int'(ev[0]));
    end
  endtask

  task automatic idle();
    cyc(0, ADD, ADD, 0, 0, 0, 0, 0, 0, 1, 0, 0, {N, 5'b0}, 3'b000);
  endtask

  initial begin : monitor
    exp_t e;
    logic [9:0] got;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        got = {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble_id_ex,
               flush_if_id, flush_id_ex, flush_ex_mem, indirect_phase};
        compared += 4;
        if (got !== e.o) begin
          mismatched++; $display("FAIL ctl t=%0t got=%b exp=%b", $time, got, e.o);
        end
        if (stall_count !== e.s) begin
          mismatched++; $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, stall_count, e.s);
        end
        if (bubble_count !== e.b) begin
          mismatched++; $display("FAIL bubble_count t=%0t got=%0d exp=%0d", $time, bubble_count, e.b);
        end
        if (flush_count !== e.f) begin
          mismatched++; $display("FAIL flush_count t=%0t got=%0d exp=%0d", $time, flush_count, e.f);
        end
      end
    end
  end

  initial begin : stim
    int guard;
    // reset held with otherwise-normal inputs: every output is 0
    cyc(1, ADD, ADD, 0, 0, 0, 0, 0, 0, 1, 0, 0, 10'b0, 3'b000);
    idle();
    // LDR R1 ; ADD R2,R1,R3 -> one bubble
    cyc(0, ADD, LDR, 1, 1, 3, 1, 1, 0, 1, 0, 0, {B, 1'b1, 3'b000, 1'b0}, 3'b010);
    cyc(0, LDR, ADD, 2, 2, 2, 0, 0, 0, 1, 0, 0, {N, 5'b0}, 3'b000);
    // LDR R1 ; ADD R2,R4,#5 (sr2 field aliases R1 but is unused) -> no bubble
    cyc(0, ADD, LDR, 1, 4, 1, 1, 0, 0, 1, 0, 0, {N, 5'b0}, 3'b000);
    // ADD R1 ; consumer of R1 -> forwarding handles it, no bubble
    cyc(0, ADD, ADD, 1, 1, 1, 1, 1, 0, 1, 0, 0, {N, 5'b0}, 3'b000);
    // LDB R3 ; match on sr2 only -> bubble
    cyc(0, ADD, LDB, 3, 0, 3, 1, 1, 0, 1, 0, 0, {B, 1'b1, 3'b000, 1'b0}, 3'b010);
    // LDI R5 ; consumer of R5 -> bubble
    cyc(0, ADD, LDI, 5, 5, 0, 1, 0, 0, 1, 0, 0, {B, 1'b1, 3'b000, 1'b0}, 3'b010);
    idle();
    idle();
    // LDI in MEM: first access completes, enter INDIRECT with all loads held
    cyc(0, LDI, ADD, 0, 0, 0, 0, 0, 0, 1, 1, 1, {Z, 5'b00000}, 3'b100);
    repeat (3) cyc(0, LDI, ADD, 0, 0, 0, 0, 0, 0, 1, 1, 0, {Z, 5'b00001}, 3'b100);
    cyc(0, LDI, ADD, 0, 0, 0, 0, 0, 0, 1, 1, 1, {N, 5'b00001}, 3'b000);
    idle();
    // taken branch beats a concurrent load-use match
    cyc(0, BR, LDR, 1, 1, 0, 1, 0, 1, 1, 0, 0, {N, 1'b0, 3'b111, 1'b0}, 3'b001);
    idle();
    // dcache miss for 5 cycles holds off a taken branch, then it flushes
    repeat (5) cyc(0, BR, ADD, 0, 0, 0, 0, 0, 1, 1, 1, 0, {Z, 5'b0}, 3'b100);
    cyc(0, BR, ADD, 0, 0, 0, 0, 0, 1, 1, 0, 0, {N, 1'b0, 3'b111, 1'b0}, 3'b001);
    // icache miss freezes
    cyc(0, ADD, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, {Z, 5'b0}, 3'b100);
    idle();
    // reset mid-INDIRECT: outputs and counters drop at once, then normal fetch
    cyc(0, LDI, ADD, 0, 0, 0, 0, 0, 0, 1, 1, 1, {Z, 5'b00000}, 3'b100);
    cyc(1, LDI, ADD, 0, 0, 0, 0, 0, 0, 1, 1, 0, 10'b0, 3'b000);
    idle();
    idle();
    // stall counter saturation
    repeat ((1 << W) + 3) cyc(0, ADD, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, {Z, 5'b0}, 3'b100);
    idle();
    idle();
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++; $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
